// File: rtl/mmc_request_arbiter_if.sv
// mmc_request_arbiter_if
//   Bundles every signal between the MMC request arbiter, its two requesters
//   (Disk II track loader and block device) and the spi_controller command
//   inputs.
//
//   Handshake: each requester raises its *_req level and holds it until the
//   arbiter answers with a one-cycle *_done pulse; the request payload
//   (disk_track / blk_num) is sampled only in the grant cycle. Toward the
//   controller, block_read_cmd / track_mode are commands and is_idle is the
//   completion indication (falls when a read starts, rises when it ends).
//
//   Modports:
//     slave  - the arbiter side (takes requests, drives controller commands)
//     master - the surrounding system (requesters + controller)
interface mmc_request_arbiter_if;
    logic        disk_req;
    logic [5:0]  disk_track;
    logic        disk_done;
    logic        blk_req;
    logic [22:0] blk_num;
    logic        blk_done;
    logic [5:0]  track;
    logic        track_mode;
    logic [22:0] block_to_read;
    logic        block_read_cmd;
    logic        is_idle;
    logic        ram_sel;
    logic        busy;
    logic        error;

    modport slave (
        input  disk_req, disk_track, blk_req, blk_num, is_idle,
        output disk_done, blk_done, track, track_mode, block_to_read,
               block_read_cmd, ram_sel, busy, error
    );

    modport master (
        output disk_req, disk_track, blk_req, blk_num, is_idle,
        input  disk_done, blk_done, track, track_mode, block_to_read,
               block_read_cmd, ram_sel, busy, error
    );
endinterface

// File: rtl/mmc_request_arbiter.sv
// mmc_request_arbiter
//   Shares one SPI MMC block reader between the Disk II track loader (full
//   nibble track, track_mode=1) and the block device (single 512-byte block,
//   block_read_cmd=1). Grants one requester at a time, round-robin on ties,
//   and detects completion from the controller's is_idle.
//
//   Ports:
//     CLK_14M   - system clock, rising edge
//     reset_n   - asynchronous active-low reset
//     arb       - mmc_request_arbiter_if.slave (requests, done pulses,
//                 controller commands, is_idle, ram_sel, busy, error)
//     dbg_state - current FSM state (INIT=0 IDLE=1 ISSUE=2 WAIT_START=3
//                 WAIT_DONE=4 DONE=5)
//
//   Optional feature: define MMC_ARB_WATCHDOG_EN to add a WAIT_DONE busy
//   watchdog that sets a sticky error, completes the owner and returns to
//   INIT. Without it error is tied to 0 and no counter exists.
module mmc_request_arbiter #(
    parameter logic [22:0] DISK_BASE_BLOCK = 23'd0,
    parameter int unsigned START_TIMEOUT   = 8,
    parameter logic [23:0] WATCHDOG_CYCLES = 24'hFFFFFF
) (
    input  logic                 CLK_14M,
    input  logic                 reset_n,
    mmc_request_arbiter_if.slave arb,
    output logic [2:0]           dbg_state
);
    typedef enum logic [2:0] {
        S_INIT       = 3'd0,
        S_IDLE       = 3'd1,
        S_ISSUE      = 3'd2,
        S_WAIT_START = 3'd3,
        S_WAIT_DONE  = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(START_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        grant_disk;
    logic        wd_expire;
    logic [5:0]  track_q, track_d;
    logic        track_mode_q, track_mode_d;
    logic [22:0] blk_q, blk_d;
    logic        cmd_q, cmd_d;
    logic        ram_sel_q, ram_sel_d;
    logic        last_grant_q, last_grant_d;   // 0 = disk, 1 = block
    logic        busy_q, busy_d;
    logic        disk_done_q, disk_done_d;
    logic        blk_done_q, blk_done_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
`ifdef MMC_ARB_WATCHDOG_EN
    logic [23:0] wd_cnt_q, wd_cnt_d;
    logic        error_q, error_d;
`else
    logic        unused_wd_cycles;
    assign unused_wd_cycles = ^WATCHDOG_CYCLES;
`endif

    // State and registered outputs
    always_ff @(posedge CLK_14M or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_INIT;
            track_q      <= '0;
            track_mode_q <= 1'b0;
            blk_q        <= DISK_BASE_BLOCK;
            cmd_q        <= 1'b0;
            ram_sel_q    <= 1'b0;
            last_grant_q <= 1'b1;   // disk wins the first tie
            busy_q       <= 1'b0;
            disk_done_q  <= 1'b0;
            blk_done_q   <= 1'b0;
            to_cnt_q     <= '0;
`ifdef MMC_ARB_WATCHDOG_EN
            wd_cnt_q     <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            track_q      <= track_d;
            track_mode_q <= track_mode_d;
            blk_q        <= blk_d;
            cmd_q        <= cmd_d;
            ram_sel_q    <= ram_sel_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            disk_done_q  <= disk_done_d;
            blk_done_q   <= blk_done_d;
            to_cnt_q     <= to_cnt_d;
`ifdef MMC_ARB_WATCHDOG_EN
            wd_cnt_q     <= wd_cnt_d;
            error_q      <= error_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        grant_disk = 1'b0;
        wd_expire  = 1'b0;
        case (state_q)
            S_INIT: begin
                // Controller card init is finished once it reports idle.
                if (arb.is_idle) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (arb.disk_req || arb.blk_req) begin
                    state_d    = S_ISSUE;
                    grant_disk = arb.disk_req && (!arb.blk_req || last_grant_q);
                end
            end
            S_ISSUE: state_d = S_WAIT_START;
            S_WAIT_START: begin
                // Staying idle for the whole window means the controller
                // already holds the requested data.
                if (!arb.is_idle)             state_d = S_WAIT_DONE;
                else if (to_cnt_q == TO_LAST) state_d = S_DONE;
            end
            S_WAIT_DONE: begin
                if (arb.is_idle) state_d = S_DONE;
`ifdef MMC_ARB_WATCHDOG_EN
                else if (wd_cnt_q == WATCHDOG_CYCLES - 24'd1) begin
                    state_d   = S_INIT;
                    wd_expire = 1'b1;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    // Output logic: next values of the registered outputs, keyed on the
    // state being entered so each output is valid in that state's first cycle.
    always_comb begin
        track_d      = track_q;
        track_mode_d = track_mode_q;
        blk_d        = blk_q;
        cmd_d        = cmd_q;
        ram_sel_d    = ram_sel_q;
        last_grant_d = last_grant_q;
        busy_d       = busy_q;
        disk_done_d  = 1'b0;
        blk_done_d   = 1'b0;
        to_cnt_d     = to_cnt_q;
        if (state_q == S_WAIT_START) to_cnt_d = to_cnt_q + 8'd1;
`ifdef MMC_ARB_WATCHDOG_EN
        wd_cnt_d = wd_cnt_q;
        error_d  = error_q | wd_expire;
        if (state_q == S_WAIT_DONE) wd_cnt_d = wd_cnt_q + 24'd1;
`endif
        case (state_d)
            S_ISSUE: begin
                busy_d       = 1'b1;
                to_cnt_d     = '0;
                last_grant_d = !grant_disk;
                ram_sel_d    = !grant_disk;
                track_mode_d = grant_disk;
                cmd_d        = !grant_disk;
                if (grant_disk) begin
                    track_d = arb.disk_track;
                    blk_d   = DISK_BASE_BLOCK;
                end else begin
                    blk_d   = arb.blk_num;
                end
`ifdef MMC_ARB_WATCHDOG_EN
                wd_cnt_d = '0;
`endif
            end
            // track_mode is held here: the controller picks its post-CRC
            // state from it.
            S_WAIT_DONE: cmd_d = 1'b0;
            default: ;
        endcase
        if (state_d == S_DONE || wd_expire) begin
            disk_done_d  = !ram_sel_q;
            blk_done_d   = ram_sel_q;
            track_mode_d = 1'b0;
            cmd_d        = 1'b0;
            busy_d       = 1'b0;
        end
    end

    assign arb.track          = track_q;
    assign arb.track_mode     = track_mode_q;
    assign arb.block_to_read  = blk_q;
    assign arb.block_read_cmd = cmd_q;
    assign arb.ram_sel        = ram_sel_q;
    assign arb.busy           = busy_q;
    assign arb.disk_done      = disk_done_q;
    assign arb.blk_done       = blk_done_q;
`ifdef MMC_ARB_WATCHDOG_EN
    assign arb.error          = error_q;
`else
    assign arb.error          = 1'b0;
`endif
    assign dbg_state          = state_q;
endmodule

// File: tb/tb_mmc_request_arbiter.sv
// tb_mmc_request_arbiter
//   Directed bench for mmc_request_arbiter. The controller is modelled by
//   driving is_idle by hand in each scenario. With MMC_ARB_WATCHDOG_EN the
//   watchdog scenario runs as well (WATCHDOG_CYCLES = 1000).
module tb_mmc_request_arbiter;
    localparam logic [22:0] BASE = 23'd100;
    localparam int          ST   = 8;
    localparam logic [23:0] WD   = 24'd1000;

    localparam logic [2:0] ST_INIT = 3'd0, ST_IDLE = 3'd1, ST_ISSUE = 3'd2,
                           ST_WAIT_DONE = 3'd4, ST_DONE = 3'd5;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] dbg_state;
    int         n_total = 0;
    int         n_bad   = 0;

    mmc_request_arbiter_if arb_if();

    mmc_request_arbiter #(
        .DISK_BASE_BLOCK(BASE),
        .START_TIMEOUT(ST),
        .WATCHDOG_CYCLES(WD)
    ) dut (
        .CLK_14M(clk),
        .reset_n(reset_n),
        .arb(arb_if.slave),
        .dbg_state(dbg_state)
    );

    // Clock / time limit
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arb_if.disk_req = 1'b0; arb_if.disk_track = 6'd0;
        arb_if.blk_req  = 1'b1; arb_if.blk_num    = 23'h12345;
        arb_if.is_idle  = 1'b0;
        reset_n = 1'b0;
        repeat (3) tick();
        n_total++;
        if ({arb_if.busy, arb_if.track_mode, arb_if.block_read_cmd, arb_if.disk_done,
             arb_if.blk_done, arb_if.ram_sel, arb_if.error} !== 7'b0 || arb_if.track !== 6'd0) begin
            n_bad++; $display("FAIL reset_outs: busy/tm/cmd/dd/bd/rs/err=%b track=%0d want all 0",
                {arb_if.busy, arb_if.track_mode, arb_if.block_read_cmd, arb_if.disk_done,
                 arb_if.blk_done, arb_if.ram_sel, arb_if.error}, arb_if.track);
        end
        n_total++;
        if (arb_if.block_to_read !== BASE) begin
            n_bad++; $display("FAIL reset_block: got %0d want %0d", arb_if.block_to_read, BASE);
        end
        n_total++;
        if (dbg_state !== ST_INIT) begin
            n_bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_INIT);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            n_total++;
            if ({arb_if.block_read_cmd, arb_if.busy} !== 2'b00) begin
                n_bad++; $display("FAIL init_no_grant: cycle %0d cmd/busy=%b want 00", i,
                    {arb_if.block_read_cmd, arb_if.busy});
            end
        end
        arb_if.is_idle = 1'b1;
        tick();
        n_total++;
        if (dbg_state !== ST_IDLE) begin
            n_bad++; $display("FAIL init_exit: state %0d want %0d", dbg_state, ST_IDLE);
        end
        tick();
        n_total++;
        if ({arb_if.block_read_cmd, arb_if.ram_sel, arb_if.busy, arb_if.track_mode} !== 4'b1110 ||
            arb_if.block_to_read !== 23'h12345) begin
            n_bad++; $display("FAIL first_blk_issue: cmd/rs/busy/tm=%b blk=%h want 1110 blk=12345",
                {arb_if.block_read_cmd, arb_if.ram_sel, arb_if.busy, arb_if.track_mode},
                arb_if.block_to_read);
        end
        arb_if.is_idle = 1'b0;
        tick(); tick();
        n_total++;
        if (dbg_state !== ST_WAIT_DONE || arb_if.block_read_cmd !== 1'b0 || arb_if.busy !== 1'b1) begin
            n_bad++; $display("FAIL first_blk_wait: state=%0d cmd=%b busy=%b want 4 0 1",
                dbg_state, arb_if.block_read_cmd, arb_if.busy);
        end
        repeat (20) tick();
        arb_if.is_idle = 1'b1;
        tick();
        n_total++;
        if ({arb_if.blk_done, arb_if.disk_done, arb_if.busy} !== 3'b100) begin
            n_bad++; $display("FAIL first_blk_done: bd/dd/busy=%b want 100",
                {arb_if.blk_done, arb_if.disk_done, arb_if.busy});
        end
        arb_if.blk_req = 1'b0;
        tick();
        n_total++;
        if (arb_if.blk_done !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_bad++; $display("FAIL first_blk_pulse: bd=%b state=%0d want 0 1", arb_if.blk_done, dbg_state);
        end
    endtask

    task automatic test_round_robin();
        bit exp_disk;
        arb_if.disk_track = 6'd12;
        arb_if.blk_num    = 23'h00abc;
        arb_if.disk_req   = 1'b1;
        arb_if.blk_req    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_disk = (i % 2 == 0);
            if (i > 0) begin
                tick();
                n_total++;
                if (dbg_state !== ST_IDLE || arb_if.busy !== 1'b0) begin
                    n_bad++; $display("FAIL rr_gap %0d: state=%0d busy=%b want 1 0", i, dbg_state, arb_if.busy);
                end
            end
            tick();
            n_total++;
            if ({arb_if.ram_sel, arb_if.busy, arb_if.block_read_cmd, arb_if.track_mode} !==
                {!exp_disk, 1'b1, !exp_disk, exp_disk} ||
                arb_if.block_to_read !== (exp_disk ? BASE : 23'h00abc)) begin
                n_bad++; $display("FAIL rr_issue %0d: rs/busy/cmd/tm=%b blk=%h want disk=%b",
                    i, {arb_if.ram_sel, arb_if.busy, arb_if.block_read_cmd, arb_if.track_mode},
                    arb_if.block_to_read, exp_disk);
            end
            if (exp_disk) begin
                n_total++;
                if (arb_if.track !== 6'd12) begin
                    n_bad++; $display("FAIL rr_track %0d: got %0d want 12", i, arb_if.track);
                end
            end
            arb_if.is_idle = 1'b0;
            repeat (3) tick();
            n_total++;
            if (dbg_state !== ST_WAIT_DONE || arb_if.block_read_cmd !== 1'b0 ||
                arb_if.track_mode !== exp_disk) begin
                n_bad++; $display("FAIL rr_wait %0d: state=%0d cmd=%b tm=%b want 4 0 %b",
                    i, dbg_state, arb_if.block_read_cmd, arb_if.track_mode, exp_disk);
            end
            arb_if.is_idle = 1'b1;
            tick();
            n_total++;
            if ({arb_if.disk_done, arb_if.blk_done} !== {exp_disk, !exp_disk}) begin
                n_bad++; $display("FAIL rr_done %0d: dd/bd=%b want %b", i,
                    {arb_if.disk_done, arb_if.blk_done}, {exp_disk, !exp_disk});
            end
        end
        arb_if.disk_req = 1'b0;
        arb_if.blk_req  = 1'b0;
        tick();
        n_total++;
        if ({arb_if.disk_done, arb_if.blk_done} !== 2'b00 || dbg_state !== ST_IDLE) begin
            n_bad++; $display("FAIL rr_end: dd/bd=%b state=%0d want 00 1",
                {arb_if.disk_done, arb_if.blk_done}, dbg_state);
        end
    endtask

    task automatic test_disk_track();
        arb_if.disk_track = 6'd5;
        arb_if.disk_req   = 1'b1;
        tick();
        n_total++;
        if (arb_if.track !== 6'd5 || arb_if.track_mode !== 1'b1 || arb_if.block_to_read !== BASE ||
            arb_if.ram_sel !== 1'b0 || arb_if.block_read_cmd !== 1'b0) begin
            n_bad++; $display("FAIL disk_issue: track=%0d tm=%b blk=%0d rs=%b cmd=%b want 5 1 %0d 0 0",
                arb_if.track, arb_if.track_mode, arb_if.block_to_read, arb_if.ram_sel,
                arb_if.block_read_cmd, BASE);
        end
        // Payload change after grant is ignored; a dropped request is still served.
        arb_if.disk_track = 6'd33;
        arb_if.disk_req   = 1'b0;
        arb_if.is_idle    = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n_total++;
            if (arb_if.track_mode !== 1'b1 || arb_if.track !== 6'd5 || arb_if.ram_sel !== 1'b0 ||
                arb_if.busy !== 1'b1) begin
                n_bad++; $display("FAIL disk_hold: cycle %0d tm=%b track=%0d rs=%b busy=%b want 1 5 0 1",
                    i, arb_if.track_mode, arb_if.track, arb_if.ram_sel, arb_if.busy);
            end
        end
        arb_if.is_idle = 1'b1;
        tick();
        n_total++;
        if ({arb_if.disk_done, arb_if.blk_done, arb_if.track_mode, arb_if.busy} !== 4'b1000) begin
            n_bad++; $display("FAIL disk_done: dd/bd/tm/busy=%b want 1000",
                {arb_if.disk_done, arb_if.blk_done, arb_if.track_mode, arb_if.busy});
        end
        tick(); tick();
        n_total++;
        if (arb_if.disk_done !== 1'b0 || arb_if.busy !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_bad++; $display("FAIL disk_after: dd=%b busy=%b state=%0d want 0 0 1",
                arb_if.disk_done, arb_if.busy, dbg_state);
        end
    endtask

    task automatic test_cached_block();
        int cycles = 0;
        bit got = 1'b0;
        arb_if.blk_num = 23'h70001;
        arb_if.blk_req = 1'b1;
        arb_if.is_idle = 1'b1;
        for (int c = 1; c <= 50 && !got; c++) begin
            tick();
            if (c == 1) arb_if.blk_num = 23'h00001;
            if (arb_if.blk_done === 1'b1) begin
                got    = 1'b1;
                cycles = c;
            end
        end
        n_total++;
        if (cycles != ST + 2) begin
            n_bad++; $display("FAIL cached_latency: got %0d cycles want %0d", cycles, ST + 2);
        end
        n_total++;
        if (arb_if.block_to_read !== 23'h70001 || arb_if.error !== 1'b0 || arb_if.busy !== 1'b0 ||
            dbg_state !== ST_DONE) begin
            n_bad++; $display("FAIL cached_state: blk=%h err=%b busy=%b state=%0d want 70001 0 0 5",
                arb_if.block_to_read, arb_if.error, arb_if.busy, dbg_state);
        end
        arb_if.blk_req = 1'b0;
        tick();
        n_total++;
        if (arb_if.blk_done !== 1'b0) begin
            n_bad++; $display("FAIL cached_pulse: bd=%b want 0", arb_if.blk_done);
        end
    endtask

    task automatic test_reset_mid();
        arb_if.disk_track = 6'd7;
        arb_if.disk_req   = 1'b1;
        tick();
        arb_if.is_idle = 1'b0;
        repeat (3) tick();
        n_total++;
        if (dbg_state !== ST_WAIT_DONE || arb_if.busy !== 1'b1) begin
            n_bad++; $display("FAIL mid_pre: state=%0d busy=%b want 4 1", dbg_state, arb_if.busy);
        end
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if ({arb_if.busy, arb_if.track_mode, arb_if.block_read_cmd, arb_if.disk_done,
             arb_if.blk_done} !== 5'b0 || dbg_state !== ST_INIT || arb_if.block_to_read !== BASE) begin
            n_bad++; $display("FAIL mid_async: busy/tm/cmd/dd/bd=%b state=%0d blk=%0d want 00000 0 %0d",
                {arb_if.busy, arb_if.track_mode, arb_if.block_read_cmd, arb_if.disk_done,
                 arb_if.blk_done}, dbg_state, arb_if.block_to_read, BASE);
        end
        tick(); tick();
        reset_n = 1'b1;
        repeat (5) tick();
        n_total++;
        if (dbg_state !== ST_INIT || arb_if.busy !== 1'b0) begin
            n_bad++; $display("FAIL mid_init: state=%0d busy=%b want 0 0", dbg_state, arb_if.busy);
        end
        arb_if.is_idle = 1'b1;
        tick(); tick();
        n_total++;
        if (dbg_state !== ST_ISSUE || arb_if.ram_sel !== 1'b0 || arb_if.track_mode !== 1'b1 ||
            arb_if.track !== 6'd7) begin
            n_bad++; $display("FAIL mid_regrant: state=%0d rs=%b tm=%b track=%0d want 2 0 1 7",
                dbg_state, arb_if.ram_sel, arb_if.track_mode, arb_if.track);
        end
        arb_if.is_idle = 1'b0;
        repeat (3) tick();
        arb_if.is_idle = 1'b1;
        tick();
        n_total++;
        if (arb_if.disk_done !== 1'b1) begin
            n_bad++; $display("FAIL mid_done: dd=%b want 1", arb_if.disk_done);
        end
        arb_if.disk_req = 1'b0;
        tick();
    endtask

`ifdef MMC_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        int cycles = 0;
        bit got = 1'b0;
        arb_if.blk_num = 23'h00055;
        arb_if.blk_req = 1'b1;
        tick();
        arb_if.is_idle = 1'b0;
        tick(); tick();
        n_total++;
        if (dbg_state !== ST_WAIT_DONE) begin
            n_bad++; $display("FAIL wd_enter: state=%0d want 4", dbg_state);
        end
        for (int c = 1; c <= 1100 && !got; c++) begin
            tick();
            if (arb_if.blk_done === 1'b1) begin
                got    = 1'b1;
                cycles = c;
            end
        end
        n_total++;
        if (cycles != 1000) begin
            n_bad++; $display("FAIL wd_latency: got %0d want 1000", cycles);
        end
        n_total++;
        if ({arb_if.error, arb_if.busy, arb_if.block_read_cmd, arb_if.track_mode} !== 4'b1000 ||
            dbg_state !== ST_INIT) begin
            n_bad++; $display("FAIL wd_state: err/busy/cmd/tm=%b state=%0d want 1000 0",
                {arb_if.error, arb_if.busy, arb_if.block_read_cmd, arb_if.track_mode}, dbg_state);
        end
        arb_if.blk_req = 1'b0;
        arb_if.is_idle = 1'b1;
        tick(); tick();
        n_total++;
        if (arb_if.error !== 1'b1 || arb_if.blk_done !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_bad++; $display("FAIL wd_sticky: err=%b bd=%b state=%0d want 1 0 1",
                arb_if.error, arb_if.blk_done, dbg_state);
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        test_reset();
        test_round_robin();
        test_disk_track();
        test_cached_block();
        test_reset_mid();
`ifdef MMC_ARB_WATCHDOG_EN
        test_watchdog();
`endif
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/mmc_request_arbiter.md
# mmc_request_arbiter

Shares the single SPI MMC block reader (`spi_controller`) between two requesters: the Disk II track loader, which needs a full 13-block nibble track, and the block device, which needs single 512-byte blocks. The arbiter sits between both requesters and the controller's command inputs. It grants one requester at a time and drives `track`, `track_mode`, `block_to_read` and `block_read_cmd`. It watches `is_idle` to detect completion and drives `ram_sel` so the top level can steer the controller's RAM write port to the owning buffer.

## Interface
- `DISK_BASE_BLOCK`, default 23'd0: first card block of the nibble disk image; driven on `block_to_read` during disk service.
- `START_TIMEOUT`, default 8: cycles to wait for `is_idle` to fall after issue before declaring the request satisfied (1–255).
- `WATCHDOG_CYCLES`, default 24'hFFFFFF: busy-cycle limit, used only with `MMC_ARB_WATCHDOG_EN`.

Ports:
- `CLK_14M`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `disk_req`  in  1  level; Disk II wants `disk_track` loaded; held until `disk_done`.
- `disk_track`  in  6  track 0–34; sampled at grant.
- `disk_done`  out  1  one-cycle pulse: disk request finished.
- `blk_req`  in  1  level; block device wants `blk_num`; held until `blk_done`.
- `blk_num`  in  23  block number; sampled at grant.
- `blk_done`  out  1  one-cycle pulse: block request finished.
- `track`  out  6  to controller.
- `track_mode`  out  1  to controller.
- `block_to_read`  out  23  to controller.
- `block_read_cmd`  out  1  to controller.
- `is_idle`  in  1  from controller; high in its IDLE state.
- `ram_sel`  out  1  0 = disk buffer owns the RAM write port, 1 = block buffer owns it; valid whenever busy.
- `busy`  out  1  high in ISSUE, WAIT_START and WAIT_DONE.
- `error`  out  1  sticky watchdog flag; constant 0 without `MMC_ARB_WATCHDOG_EN`.

## Operation
- All outputs are registered. Reset values are all 0, except `block_to_read`, which resets to `DISK_BASE_BLOCK`. State resets to INIT and `last_grant` resets to 1 (block), so the disk wins the first tie.
- **INIT:** wait for `is_idle`=1, i.e. the controller's card init is finished. Then go to IDLE. No requests are granted in INIT.
- **IDLE:** arbitrate in round-robin fashion.
  - With a single request pending, grant it.
  - With both pending, grant the requester opposite `last_grant`.
  - On a grant: latch track/block, set `ram_sel` and `last_grant`, and go to ISSUE.
- **ISSUE, disk granted:** `track_mode`=1, `track`=latched track, `block_to_read`=`DISK_BASE_BLOCK`, `block_read_cmd`=0.
- **ISSUE, block granted:** `block_read_cmd`=1, `block_to_read`=latched block, `track_mode`=0.
- ISSUE always goes to WAIT_START on the next cycle. Clear the timeout counter.
- **WAIT_START:**
  - If `is_idle`=0, go to WAIT_DONE.
  - Otherwise, when the counter reaches `START_TIMEOUT`-1, go to DONE. The controller skipped the request because the track or block is already loaded; the buffer is valid.
- **WAIT_DONE:**
  - Deassert `block_read_cmd` on entry.
  - Hold `track_mode`=1 for the whole of WAIT_DONE when the disk is granted. The controller selects its post-CRC state from `track_mode`.
  - On `is_idle`=1, go to DONE.
- **DONE:** pulse `disk_done` or `blk_done` (whichever matches the owner) for one cycle. Clear `track_mode` and `busy`. Go to IDLE.
- Changes on `disk_track` or `blk_num` after the grant are ignored until the next grant.
- A requester that drops its request while busy is still serviced, and still receives its done pulse.

## Timing
- Grant latency: request seen in IDLE at cycle N → ISSUE outputs visible at N+1.
- Controller reaction: `is_idle` falls at N+2 when a read is needed.
- Fastest cached completion: done pulse at N+2+`START_TIMEOUT`.
- The done pulse is one cycle wide. The earliest next grant is evaluated in the IDLE cycle after DONE, so back-to-back requests from opposite requesters alternate.
- The track field is 6 bits; the arbiter does not range-check tracks greater than 34.
- `reset_n` asserted mid-operation: all outputs clear asynchronously and state returns to INIT. The controller is reset by the same top-level reset, so no command remains in flight.

## Configuration
- **`MMC_ARB_WATCHDOG_EN` defined:** a 24-bit busy counter runs in WAIT_DONE.
  - On reaching `WATCHDOG_CYCLES`: set `error` (sticky until reset), pulse the owner's done signal, clear `track_mode`/`block_read_cmd`, and go to INIT. INIT waits for `is_idle` before the next grant.
- **Not defined:** WAIT_DONE waits indefinitely, `error` is tied to 0, and no counter is synthesized.

## Test plan
- Reset release with the controller model holding `is_idle`=0 for 100 cycles and `blk_req`=1 → no `block_read_cmd` until `is_idle` rises. Then `block_to_read`=`blk_num`, and `blk_done` pulses once after `is_idle` returns to 1.
- `disk_req` with `disk_track`=5, controller busy for 200 cycles → `track_mode`=1 and `track`=5 throughout. `block_to_read`=`DISK_BASE_BLOCK`, `ram_sel`=0, `disk_done` one cycle after `is_idle` rises.
- `disk_req` and `blk_req` both asserted from IDLE → disk granted first. The block is granted immediately after `disk_done`. Repeat both → the order alternates.
- Block request for the already-loaded block, with `is_idle` never falling → `blk_done` exactly `START_TIMEOUT`+2 cycles after the request, with no error.
- `reset_n` pulsed low during WAIT_DONE → `busy`, `track_mode`, `block_read_cmd` and done all 0 immediately; state returns to INIT.
- With `MMC_ARB_WATCHDOG_EN` and `WATCHDOG_CYCLES`=1000, controller stuck busy → `error`=1 and `blk_done` pulse at cycle 1000 of WAIT_DONE, then INIT.
